// File: rtl/nanorv32_periph_arb_if.sv
// Bus bundle for nanorv32_periph_arb: both master request/response ports,
// the shared peripheral slave port and the busy flag.
// The slave modport is the arbiter's view. The master modport is the
// environment's view: both bus masters plus the peripheral mux.
interface nanorv32_periph_arb_if #(
  parameter int AW = 13,
  parameter int DW = 32
);
  logic          m0_req;
  logic          m0_we;
  logic [AW-1:0] m0_addr;
  logic [3:0]    m0_bytesel;
  logic [DW-1:0] m0_wdata;
  logic [DW-1:0] m0_rdata;
  logic          m0_ready;
  logic          m0_err;

  logic          m1_req;
  logic          m1_we;
  logic [AW-1:0] m1_addr;
  logic [3:0]    m1_bytesel;
  logic [DW-1:0] m1_wdata;
  logic [DW-1:0] m1_rdata;
  logic          m1_ready;
  logic          m1_err;

  logic          periph_en;
  logic          periph_we;
  logic [AW-1:0] periph_addr;
  logic [3:0]    periph_bytesel;
  logic [DW-1:0] periph_din;
  logic [DW-1:0] periph_dout;
  logic          periph_ready_nxt;
  logic          arb_busy;

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_bytesel, m0_wdata,
    input  m1_req, m1_we, m1_addr, m1_bytesel, m1_wdata,
    output m0_rdata, m0_ready, m0_err, m1_rdata, m1_ready, m1_err,
    output periph_en, periph_we, periph_addr, periph_bytesel, periph_din,
    input  periph_dout, periph_ready_nxt,
    output arb_busy
  );

  modport master (
    output m0_req, m0_we, m0_addr, m0_bytesel, m0_wdata,
    output m1_req, m1_we, m1_addr, m1_bytesel, m1_wdata,
    input  m0_rdata, m0_ready, m0_err, m1_rdata, m1_ready, m1_err,
    input  periph_en, periph_we, periph_addr, periph_bytesel, periph_din,
    output periph_dout, periph_ready_nxt,
    input  arb_busy
  );
endinterface

// File: rtl/nanorv32_periph_arb.sv
// nanorv32_periph_arb: round-robin two-master arbiter and IDLE/ACCESS/DATA
// sequencer for the peripheral bus.
// Optional feature macro: NANORV32_PERIPH_ARB_TIMEOUT_EN. When it is defined,
// an access is aborted with err after TIMEOUT ACCESS cycles without
// periph_ready_nxt.
module nanorv32_periph_arb #(
  parameter int AW      = 13,
  parameter int DW      = 32,
  parameter int TIMEOUT = 16
) (
  input logic clk,
  input logic rst,
  nanorv32_periph_arb_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, DATA} state_t;

  state_t        state_reg, state_next;
  logic          grant_reg;
  logic          last_grant_reg;
  logic          periph_we_reg;
  logic [AW-1:0] periph_addr_reg;
  logic [3:0]    periph_bytesel_reg;
  logic [DW-1:0] periph_din_reg;
  logic          m0_ready_reg, m1_ready_reg;
  logic [DW-1:0] m0_rdata_reg, m1_rdata_reg;

  logic elig0, elig1, win;
  logic load, done, abort, timeout_hit;

  // Elaboration-time guard on the timeout range.
  if (TIMEOUT < 2 || TIMEOUT > 256) begin : g_bad_timeout
    $error("nanorv32_periph_arb: TIMEOUT must lie in 2..256");
  end

  // A master still showing its ready pulse is holding a stale request.
  assign elig0 = bus.m0_req & ~m0_ready_reg;
  assign elig1 = bus.m1_req & ~m1_ready_reg;
  // On a tie the master that was not served last wins.
  assign win   = (elig0 & elig1) ? ~last_grant_reg : elig1;

`ifdef NANORV32_PERIPH_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT);
  logic [CW-1:0] cnt_reg;
  logic          m0_err_reg, m1_err_reg;

  // The counter holds (k-1) during the k-th ACCESS cycle.
  assign timeout_hit = (state_reg == ACCESS) && !bus.periph_ready_nxt &&
                       (cnt_reg == CW'(TIMEOUT - 1));

  // Wait-cycle counter: cleared when a grant is made, counts stalled cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (load) begin
      cnt_reg <= '0;
    end else if (state_reg == ACCESS && !bus.periph_ready_nxt) begin
      cnt_reg <= cnt_reg + CW'(1);
    end
  end

  // Error flags of the granted master follow each completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      m0_err_reg <= 1'b0;
      m1_err_reg <= 1'b0;
    end else if (done || abort) begin
      if (grant_reg) m1_err_reg <= abort;
      else           m0_err_reg <= abort;
    end
  end

  assign bus.m0_err = m0_err_reg;
  assign bus.m1_err = m1_err_reg;
`else
  assign timeout_hit = 1'b0;
  assign bus.m0_err  = 1'b0;
  assign bus.m1_err  = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next-state decode and phase strobes.
  always_comb begin
    state_next = state_reg;
    load       = 1'b0;
    done       = 1'b0;
    abort      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (elig0 || elig1) begin
          state_next = ACCESS;
          load       = 1'b1;
        end
      end
      ACCESS: begin
        if (bus.periph_ready_nxt) begin
          state_next = DATA;
        end else if (timeout_hit) begin
          state_next = IDLE;
          abort      = 1'b1;
        end
      end
      DATA: begin
        state_next = IDLE;
        done       = 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

  // Grant latch, peripheral request registers and master responses.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_reg          <= 1'b0;
      last_grant_reg     <= 1'b1;
      periph_we_reg      <= 1'b0;
      periph_addr_reg    <= '0;
      periph_bytesel_reg <= '0;
      periph_din_reg     <= '0;
      m0_ready_reg       <= 1'b0;
      m1_ready_reg       <= 1'b0;
      m0_rdata_reg       <= '0;
      m1_rdata_reg       <= '0;
    end else begin
      m0_ready_reg <= 1'b0;
      m1_ready_reg <= 1'b0;
      if (load) begin
        grant_reg          <= win;
        periph_we_reg      <= win ? bus.m1_we      : bus.m0_we;
        periph_addr_reg    <= win ? bus.m1_addr    : bus.m0_addr;
        periph_bytesel_reg <= win ? bus.m1_bytesel : bus.m0_bytesel;
        periph_din_reg     <= win ? bus.m1_wdata   : bus.m0_wdata;
      end
      if (done || abort) begin
        last_grant_reg <= grant_reg;
        if (grant_reg) begin
          m1_ready_reg <= 1'b1;
          if (abort)               m1_rdata_reg <= '0;
          else if (!periph_we_reg) m1_rdata_reg <= bus.periph_dout;
        end else begin
          m0_ready_reg <= 1'b1;
          if (abort)               m0_rdata_reg <= '0;
          else if (!periph_we_reg) m0_rdata_reg <= bus.periph_dout;
        end
      end
    end
  end

  assign bus.periph_en      = (state_reg == ACCESS);
  assign bus.arb_busy       = (state_reg != IDLE);
  assign bus.periph_we      = periph_we_reg;
  assign bus.periph_addr    = periph_addr_reg;
  assign bus.periph_bytesel = periph_bytesel_reg;
  assign bus.periph_din     = periph_din_reg;
  assign bus.m0_ready       = m0_ready_reg;
  assign bus.m1_ready       = m1_ready_reg;
  assign bus.m0_rdata       = m0_rdata_reg;
  assign bus.m1_rdata       = m1_rdata_reg;

endmodule

// File: tb/tb_nanorv32_periph_arb.sv
// Directed testbench for nanorv32_periph_arb. Inputs change 1 time unit after
// the rising edge and outputs are sampled at that same point.
module tb_nanorv32_periph_arb;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  nanorv32_periph_arb_if #(.AW(13), .DW(32)) bus ();

  nanorv32_periph_arb #(.AW(13), .DW(32), .TIMEOUT(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // One line per completed transaction.
  always @(negedge clk) begin
    if (bus.m0_ready) $display("txn m0 rdata=%08h err=%0b", bus.m0_rdata, bus.m0_err);
    if (bus.m1_ready) $display("txn m1 rdata=%08h err=%0b", bus.m1_rdata, bus.m1_err);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.m0_req = 0; bus.m0_we = 0; bus.m0_addr = '0; bus.m0_bytesel = '0; bus.m0_wdata = '0;
    bus.m1_req = 0; bus.m1_we = 0; bus.m1_addr = '0; bus.m1_bytesel = '0; bus.m1_wdata = '0;
    bus.periph_dout = '0; bus.periph_ready_nxt = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if ({bus.periph_en, bus.arb_busy, bus.m0_ready, bus.m1_ready, bus.m0_err, bus.m1_err} !== 6'b0) begin
      n_bad++; $display("FAIL reset_flags got=%b want=000000",
        {bus.periph_en, bus.arb_busy, bus.m0_ready, bus.m1_ready, bus.m0_err, bus.m1_err});
    end
    n_cmp++;
    if ({bus.m0_rdata, bus.m1_rdata, bus.periph_din, bus.periph_addr, bus.periph_bytesel, bus.periph_we} !== '0) begin
      n_bad++; $display("FAIL reset_data got m0=%h m1=%h din=%h addr=%h bs=%h we=%b want all 0",
        bus.m0_rdata, bus.m1_rdata, bus.periph_din, bus.periph_addr, bus.periph_bytesel, bus.periph_we);
    end
  endtask

  task automatic test_read();
    do_reset();
    bus.m0_req = 1; bus.m0_addr = 13'h010; bus.periph_ready_nxt = 1; bus.periph_dout = 32'h12345678;
    tick(); // cycle 1
    n_cmp++;
    if ({bus.periph_en, bus.periph_addr, bus.periph_we} !== {1'b1, 13'h010, 1'b0}) begin
      n_bad++; $display("FAIL read_c1 en=%b addr=%h we=%b want en=1 addr=010 we=0",
        bus.periph_en, bus.periph_addr, bus.periph_we);
    end
    tick(); // cycle 2
    n_cmp++;
    if ({bus.periph_en, bus.arb_busy, bus.m0_ready} !== 3'b010) begin
      n_bad++; $display("FAIL read_c2 en/busy/ready=%b want 010", {bus.periph_en, bus.arb_busy, bus.m0_ready});
    end
    tick(); // cycle 3
    n_cmp++;
    if ({bus.m0_ready, bus.m0_err, bus.m0_rdata} !== {1'b1, 1'b0, 32'h12345678}) begin
      n_bad++; $display("FAIL read_c3 ready=%b err=%b rdata=%h want 1 0 12345678",
        bus.m0_ready, bus.m0_err, bus.m0_rdata);
    end
    n_cmp++;
    if ({bus.m1_ready, bus.m1_err, bus.m1_rdata} !== '0) begin
      n_bad++; $display("FAIL read_m1_quiet ready=%b err=%b rdata=%h want 0", bus.m1_ready, bus.m1_err, bus.m1_rdata);
    end
    bus.m0_req = 0;
    tick(); // cycle 4
    n_cmp++;
    if ({bus.periph_en, bus.m0_ready, bus.arb_busy} !== 3'b000) begin
      n_bad++; $display("FAIL read_c4 en/ready/busy=%b want 000", {bus.periph_en, bus.m0_ready, bus.arb_busy});
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    bus.m0_req = 1; bus.m0_addr = 13'h100;
    bus.m1_req = 1; bus.m1_addr = 13'h200;
    bus.periph_ready_nxt = 1; bus.periph_dout = 32'h11111111;
    tick(); // c1
    n_cmp++;
    if ({bus.periph_en, bus.periph_addr} !== {1'b1, 13'h100}) begin
      n_bad++; $display("FAIL rr_first en=%b addr=%h want 1 100", bus.periph_en, bus.periph_addr);
    end
    tick(); tick(); // c3
    n_cmp++;
    if ({bus.m0_ready, bus.m1_ready, bus.m0_rdata} !== {1'b1, 1'b0, 32'h11111111}) begin
      n_bad++; $display("FAIL rr_m0_done r0=%b r1=%b rdata=%h want 1 0 11111111", bus.m0_ready, bus.m1_ready, bus.m0_rdata);
    end
    bus.m0_req = 0;
    tick(); // c4
    n_cmp++;
    if ({bus.periph_en, bus.periph_addr} !== {1'b1, 13'h200}) begin
      n_bad++; $display("FAIL rr_second en=%b addr=%h want 1 200", bus.periph_en, bus.periph_addr);
    end
    bus.periph_dout = 32'h22222222;
    tick(); tick(); // c6
    n_cmp++;
    if ({bus.m1_ready, bus.m1_rdata, bus.m0_ready, bus.m0_rdata} !== {1'b1, 32'h22222222, 1'b0, 32'h11111111}) begin
      n_bad++; $display("FAIL rr_m1_done r1=%b d1=%h r0=%b d0=%h want 1 22222222 0 11111111",
        bus.m1_ready, bus.m1_rdata, bus.m0_ready, bus.m0_rdata);
    end
    bus.m1_req = 0;
    tick(); // c7: both again
    bus.m0_req = 1; bus.m1_req = 1;
    tick(); // c8
    n_cmp++;
    if ({bus.periph_en, bus.periph_addr} !== {1'b1, 13'h100}) begin
      n_bad++; $display("FAIL rr_third en=%b addr=%h want 1 100", bus.periph_en, bus.periph_addr);
    end
    tick(); tick(); // c10
    bus.m0_req = 0;
    tick(); // c11
    n_cmp++;
    if ({bus.periph_en, bus.periph_addr} !== {1'b1, 13'h200}) begin
      n_bad++; $display("FAIL rr_fourth en=%b addr=%h want 1 200", bus.periph_en, bus.periph_addr);
    end
    tick(); tick(); // c13
    bus.m1_req = 0;
    tick();
  endtask

  task automatic test_write_wait();
    do_reset();
    bus.m1_req = 1; bus.m1_we = 1; bus.m1_addr = 13'h044; bus.m1_bytesel = 4'b0011;
    bus.m1_wdata = 32'hCAFEF00D; bus.periph_dout = 32'hDEADBEEF; bus.periph_ready_nxt = 0;
    for (int c = 1; c <= 5; c++) begin
      tick();
      bus.m1_wdata = 32'h0BADF00D; bus.m1_bytesel = 4'b1100; // must be ignored
      n_cmp++;
      if ({bus.periph_en, bus.periph_we, bus.periph_bytesel, bus.periph_din} !== {1'b1, 1'b1, 4'b0011, 32'hCAFEF00D}) begin
        n_bad++; $display("FAIL wr_access_c%0d en=%b we=%b bs=%b din=%h want 1 1 0011 cafef00d",
          c, bus.periph_en, bus.periph_we, bus.periph_bytesel, bus.periph_din);
      end
      if (c == 5) bus.periph_ready_nxt = 1;
    end
    tick(); // c6
    n_cmp++;
    if ({bus.periph_en, bus.arb_busy, bus.m1_ready} !== 3'b010) begin
      n_bad++; $display("FAIL wr_c6 en/busy/ready=%b want 010", {bus.periph_en, bus.arb_busy, bus.m1_ready});
    end
    tick(); // c7
    n_cmp++;
    if ({bus.m1_ready, bus.m1_err, bus.m1_rdata, bus.m0_ready} !== {1'b1, 1'b0, 32'h0, 1'b0}) begin
      n_bad++; $display("FAIL wr_c7 r1=%b e1=%b d1=%h r0=%b want 1 0 00000000 0",
        bus.m1_ready, bus.m1_err, bus.m1_rdata, bus.m0_ready);
    end
    bus.m1_req = 0; bus.m1_we = 0;
    tick();
  endtask

  task automatic test_hold_req();
    do_reset();
    bus.m0_req = 1; bus.m0_addr = 13'h020; bus.periph_ready_nxt = 1; bus.periph_dout = 32'h55AA55AA;
    tick(); tick(); tick(); // c3
    n_cmp++;
    if ({bus.m0_ready, bus.m0_rdata} !== {1'b1, 32'h55AA55AA}) begin
      n_bad++; $display("FAIL hold_c3 ready=%b rdata=%h want 1 55aa55aa", bus.m0_ready, bus.m0_rdata);
    end
    tick(); // c4
    n_cmp++;
    if ({bus.periph_en, bus.arb_busy, bus.m0_ready} !== 3'b000) begin
      n_bad++; $display("FAIL hold_c4 en/busy/ready=%b want 000", {bus.periph_en, bus.arb_busy, bus.m0_ready});
    end
    tick(); // c5
    n_cmp++;
    if (bus.periph_en !== 1'b1) begin
      n_bad++; $display("FAIL hold_c5 en=%b want 1", bus.periph_en);
    end
    bus.m0_req = 0;
    tick(); tick(); tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.m0_req = 1; bus.m0_addr = 13'h0F0; bus.periph_ready_nxt = 0; bus.periph_dout = 32'h0C0FFEE0;
    tick(); tick(); // c2, second ACCESS cycle
    n_cmp++;
    if (bus.periph_en !== 1'b1) begin
      n_bad++; $display("FAIL rstmid_c2 en=%b want 1", bus.periph_en);
    end
    rst = 1'b1;
    tick(); // c3
    n_cmp++;
    if ({bus.periph_en, bus.arb_busy, bus.m0_ready, bus.m1_ready, bus.periph_addr, bus.m0_rdata} !== '0) begin
      n_bad++; $display("FAIL rstmid_c3 en=%b busy=%b r0=%b r1=%b addr=%h d0=%h want all 0",
        bus.periph_en, bus.arb_busy, bus.m0_ready, bus.m1_ready, bus.periph_addr, bus.m0_rdata);
    end
    rst = 1'b0;
    tick(); // c4
    n_cmp++;
    if ({bus.periph_en, bus.periph_addr, bus.m0_ready} !== {1'b1, 13'h0F0, 1'b0}) begin
      n_bad++; $display("FAIL rstmid_c4 en=%b addr=%h ready=%b want 1 0f0 0", bus.periph_en, bus.periph_addr, bus.m0_ready);
    end
    bus.periph_ready_nxt = 1;
    tick(); tick(); // c6
    n_cmp++;
    if ({bus.m0_ready, bus.m0_rdata} !== {1'b1, 32'h0C0FFEE0}) begin
      n_bad++; $display("FAIL rstmid_c6 ready=%b rdata=%h want 1 0c0ffee0", bus.m0_ready, bus.m0_rdata);
    end
    bus.m0_req = 0;
    tick();
  endtask

`ifdef NANORV32_PERIPH_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int  en_cycles;
    bit  seen;
    do_reset();
    bus.m0_req = 1; bus.m0_addr = 13'h008; bus.periph_ready_nxt = 1; bus.periph_dout = 32'h00000077;
    tick(); tick(); tick();
    bus.m0_req = 0;
    tick();
    bus.m0_req = 1; bus.periph_ready_nxt = 0;
    en_cycles = 0;
    seen = 0;
    for (int c = 0; c < 40 && !seen; c++) begin
      tick();
      if (bus.periph_en) en_cycles++;
      if (bus.m0_ready) seen = 1;
    end
    n_cmp++;
    if (!seen || en_cycles != 16) begin
      n_bad++; $display("FAIL timeout_len seen=%0b en_cycles=%0d want 1 16", seen, en_cycles);
    end
    n_cmp++;
    if ({bus.m0_err, bus.m0_rdata, bus.arb_busy} !== {1'b1, 32'h0, 1'b0}) begin
      n_bad++; $display("FAIL timeout_resp err=%b rdata=%h busy=%b want 1 00000000 0", bus.m0_err, bus.m0_rdata, bus.arb_busy);
    end
    bus.m0_req = 0;
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_read();
    test_round_robin();
    test_write_wait();
    test_hold_req();
    test_reset_mid();
`ifdef NANORV32_PERIPH_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
